dm_cache_ctrl: RTL and testbench
================================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameter: TAG_W, 20, tag width (address[31:12]).
REQ-002 Parameter: IDX_W, 8, index width (address[11:4]), 256 lines.
REQ-003 Parameter: OFF_W, 4, word-offset width (address[3:0]), 16 x 32-bit words per line.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  in  1  CPU read request.
REQ-007 Port: req_ready  out  1  controller can accept a request.
REQ-008 Port: req_addr  in  32  word address {tag, index, offset}.
REQ-009 Port: resp_valid  out  1  one-cycle response strobe.
REQ-010 Port: resp_data  out  32  read data, valid while resp_valid.
REQ-011 Port: resp_hit  out  1  1 = hit, 0 = miss, valid while resp_valid.
REQ-012 Port: mem_req  out  1  refill word request to backing memory.
REQ-013 Port: mem_addr  out  32  refill word address.
REQ-014 Port: mem_ack  in  1  memory returns mem_rdata this cycle.
REQ-015 Port: mem_rdata  in  32  refill word.
REQ-016 Ports (macro only): hit_count, miss_count  out  32 each  saturating statistics.

Function
REQ-017 Internal storage: per line a valid bit, TAG_W tag, 16 x 32-bit data words.
REQ-018 FSM states: IDLE, LOOKUP, REFILL, RESPOND; no other states.
REQ-019 IDLE: req_ready=1; req_valid=1 latches req_addr and moves to LOOKUP; otherwise stays in IDLE.
REQ-020 req_ready=0 in all states other than IDLE; req_valid is ignored there.
REQ-021 LOOKUP: valid[index] and tag match -> capture data[index][offset], hit flag=1, go to RESPOND.
REQ-022 LOOKUP miss: clear valid[index], word counter=0, go to REFILL.
REQ-023 REFILL: mem_req=1 continuously; mem_addr={latched tag, latched index, counter}.
REQ-024 Each cycle with mem_ack=1 in REFILL: write mem_rdata to data[index][counter], then increment counter.
REQ-025 When counter==offset on an ack, capture mem_rdata as response data.
REQ-026 Ack at counter==15: set tag[index], set valid[index]=1, hit flag=0, go to RESPOND.
REQ-027 mem_ack outside REFILL is ignored; mem_req=0 outside REFILL.
REQ-028 RESPOND: resp_valid=1 for exactly one cycle with resp_data/resp_hit, then IDLE.
REQ-029 Latency: hit -> resp_valid on 2nd rising edge after acceptance edge; miss -> 1 cycle after 16th ack.
REQ-030 resp_data and resp_hit hold their last value when resp_valid=0.
REQ-031 Back-to-back: earliest next acceptance is the cycle after RESPOND; a miss refill is visible to the next request (same line hits).
REQ-032 Conflicting tag on the same index evicts the line; no write-back (read-only cache).

Reset
REQ-033 reset=1 asynchronously forces IDLE, clears all valid bits, counter=0.
REQ-034 Reset values: req_ready=0 while reset asserted, 1 in first cycle after release; resp_valid=0, resp_data=0, resp_hit=0, mem_req=0, mem_addr=0.
REQ-035 Reset during REFILL aborts the refill; the line stays invalid; partial data is not used.
REQ-036 Tag and data arrays are not reset.

Configuration
REQ-037 Macro DM_CACHE_STATS_EN defined: hit_count/miss_count ports exist, reset to 0, increment on each RESPOND with resp_hit=1 / resp_hit=0, saturate at 32'hFFFFFFFF.
REQ-038 DM_CACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-039 After reset, read 0x0000_1234 with memory word n = n*3 -> 16 mem_req words 0x0000_1230..0x0000_123F, resp_hit=0, resp_data=0x0000_369C.
REQ-040 Repeat read 0x0000_1235 -> resp_hit=1, resp_data=0x0000_369F, resp_valid 2 cycles after acceptance, mem_req stays 0.
REQ-041 Read 0x0000_2234 (same index, new tag) -> miss, refill 0x0000_2230..0x0000_223F; then 0x0000_1234 -> miss again.
REQ-042 Assert reset after 5th ack of a refill -> IDLE, mem_req=0; same address re-read -> miss with full 16-word refill.
REQ-043 Hold req_valid=1 during REFILL with mem_ack stalled 3 cycles between words -> no second acceptance, mem_addr stable during stalls.
REQ-044 With DM_CACHE_STATS_EN: scenarios 039-041 -> hit_count=1, miss_count=3; reset -> both 0.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, read-only cache controller.
// 256 lines of 16 x 32-bit words. Word address = {tag[31:12], index[11:4], offset[3:0]}.
// A miss refills the whole line, one word per mem_ack, from word 0 to word 15.
// Optional hit/miss statistics ports are built when DM_CACHE_STATS_EN is defined.
//
// Request handshake: a request transfers on a rising clk edge where req_valid && req_ready.
// req_ready is high only while the controller is idle, and req_valid is ignored otherwise.
// There is no backpressure on the response: resp_valid is a single-cycle strobe.
module dm_cache_ctrl #(
   parameter int TAG_W = 20,
   parameter int IDX_W = 8,
   parameter int OFF_W = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_hit,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
`ifdef DM_CACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   output logic [1:0]  state_dbg
);

   localparam int LINES = 1 << IDX_W;
   localparam int WORDS = 1 << OFF_W;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOOKUP  = 2'd1,
      S_REFILL  = 2'd2,
      S_RESPOND = 2'd3
   } state_t;

   state_t             state_q;
   logic [31:0]        addr_q;
   logic [OFF_W-1:0]   cnt_q;
   logic [31:0]        cap_data_q;
   logic               cap_hit_q;
   logic               resp_valid_q;
   logic [31:0]        resp_data_q;
   logic               resp_hit_q;
   logic               mem_req_q;
   logic [31:0]        mem_addr_q;
   logic [LINES-1:0]   valid_q;

   // Tag and data storage carry no reset; only the valid bits qualify them.
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [31:0]        data_q [LINES][WORDS];

   logic [TAG_W-1:0]   addr_tag;
   logic [IDX_W-1:0]   addr_idx;
   logic [OFF_W-1:0]   addr_off;
   logic               lookup_hit;
   logic               refill_ack;
   logic               last_word;

   assign addr_tag   = addr_q[31 -: TAG_W];
   assign addr_idx   = addr_q[OFF_W +: IDX_W];
   assign addr_off   = addr_q[OFF_W-1:0];
   assign lookup_hit = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
   assign refill_ack = (state_q == S_REFILL) && mem_ack;
   assign last_word  = &cnt_q;

   // Ready is decoded from state so it is high in the very first cycle after reset release.
   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_hit   = resp_hit_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign state_dbg  = state_q;

`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

   // Line storage: each acknowledged refill word lands in the line; the last word installs the tag.
   always_ff @(posedge clk) begin
      if (refill_ack) begin
         data_q[addr_idx][cnt_q] <= mem_rdata;
         if (last_word) begin
            tag_q[addr_idx] <= addr_tag;
         end
      end
   end

   // Controller FSM with registered outputs, valid bits and optional statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         cap_data_q   <= '0;
         cap_hit_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_hit_q   <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         valid_q      <= '0;
`ifdef DM_CACHE_STATS_EN
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (lookup_hit) begin
                  cap_data_q <= data_q[addr_idx][addr_off];
                  cap_hit_q  <= 1'b1;
                  state_q    <= S_RESPOND;
               end else begin
                  // The line is invalid until its final word arrives, so an aborted refill is never used.
                  valid_q[addr_idx] <= 1'b0;
                  cnt_q             <= '0;
                  mem_req_q         <= 1'b1;
                  mem_addr_q        <= {addr_tag, addr_idx, {OFF_W{1'b0}}};
                  state_q           <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (mem_ack) begin
                  if (cnt_q == addr_off) begin
                     cap_data_q <= mem_rdata;
                  end
                  if (last_word) begin
                     valid_q[addr_idx] <= 1'b1;
                     cap_hit_q         <= 1'b0;
                     mem_req_q         <= 1'b0;
                     state_q           <= S_RESPOND;
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     mem_addr_q <= {addr_tag, addr_idx, cnt_q + 1'b1};
                  end
               end
            end
            S_RESPOND: begin
               resp_valid_q <= 1'b1;
               resp_data_q  <= cap_data_q;
               resp_hit_q   <= cap_hit_q;
               state_q      <= S_IDLE;
`ifdef DM_CACHE_STATS_EN
               if (cap_hit_q) begin
                  if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
               end else begin
                  if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed and randomized read traffic against a line-level cache model.
// Backing memory returns word address * 3. Build with DM_CACHE_STATS_EN to also check statistics.
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_hit;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [1:0]  state_dbg;
`ifdef DM_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: which tag each line currently holds, plus response statistics.
   bit          mdl_valid [256];
   logic [19:0] mdl_tag   [256];
   int          mdl_hits   = 0;
   int          mdl_misses = 0;

   dm_cache_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_hit   (resp_hit),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
`ifdef DM_CACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .state_dbg  (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mdl_valid[i] = 1'b0;
      mdl_hits   = 0;
      mdl_misses = 0;
   endtask

   // Full reset pulse applied away from the clock edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = 1'b0;
      mem_ack = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   // One read transaction. stall_max: wait cycles before each refill word (fixed or random up to).
   // abort_after: non-zero asserts reset right after that many acks. hold_valid keeps req_valid high.
   task automatic do_read(input logic [31:0] addr, input int stall_max, input bit fixed_stall,
                          input int abort_after, input bit hold_valid);
      int          idx;
      logic [19:0] tg;
      bit          exp_hit;
      logic [31:0] exp_data;
      logic [31:0] word_addr;
      logic [3:0]  k;
      int          acks, cyc, stall, last_ack, w, limit;
      bit          done, aborted;

      idx      = int'(addr[11:4]);
      tg       = addr[31:12];
      exp_hit  = mdl_valid[idx] && (mdl_tag[idx] == tg);
      exp_data = addr * 32'd3;
      acks = 0; cyc = 0; last_ack = 0; w = 0; done = 1'b0; aborted = 1'b0;
      limit = 16 * (stall_max + 1) + 12;
      stall = fixed_stall ? stall_max : $urandom_range(0, stall_max);

      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      @(posedge clk);
      @(negedge clk);
      cyc = 1;
      if (hold_valid) req_addr = ~addr;
      else req_valid = 1'b0;

      while (!done && !aborted && cyc < limit) begin
         if (resp_valid) begin
            done = 1'b1;
            chk("resp_hit", {31'd0, resp_hit}, {31'd0, exp_hit});
            chk("resp_data", resp_data, exp_data);
            chk("resp_latency", cyc, exp_hit ? 32'd3 : last_ack + 2);
            if (!exp_hit) chk("refill_ack_count", acks, 32'd16);
            req_valid = 1'b0;
            mem_ack   = 1'b0;
         end else begin
            chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (exp_hit) begin
               chk("mem_req_on_hit", {31'd0, mem_req}, 32'd0);
            end else begin
               chk("mem_req_refill", {31'd0, mem_req}, {31'd0, (cyc >= 2) && (acks < 16)});
            end
            if (!exp_hit && mem_req && acks < 16) begin
               k = acks[3:0];
               word_addr = {addr[31:4], k};
               chk("mem_addr", mem_addr, word_addr);
               if (stall == 0) begin
                  mem_ack   = 1'b1;
                  mem_rdata = word_addr * 32'd3;
                  acks++;
                  last_ack  = cyc;
                  stall = fixed_stall ? stall_max : $urandom_range(0, stall_max);
               end else begin
                  mem_ack   = 1'b0;
                  mem_rdata = $urandom;
                  stall--;
               end
            end else begin
               // Stray acks while no refill is running must be ignored.
               mem_ack   = 1'($urandom_range(0, 1));
               mem_rdata = $urandom;
            end
            @(posedge clk);
            if (abort_after != 0 && acks == abort_after) begin
               aborted = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
               reset   = 1'b1;
               req_valid = 1'b0;
               #1;
               chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
               chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
               chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
               model_clear();
               @(negedge clk);
               reset = 1'b0;
               #1;
               chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
            end else begin
               @(negedge clk);
               cyc++;
            end
         end
      end
      mem_ack = 1'b0;
      chk("transaction_ended", {31'd0, done | aborted}, 32'd1);

      if (done) begin
         if (exp_hit) begin
            mdl_hits++;
         end else begin
            mdl_misses++;
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = tg;
         end
         @(negedge clk);
         chk("resp_valid_pulse", {31'd0, resp_valid}, 32'd0);
         chk("resp_data_hold", resp_data, exp_data);
         chk("resp_hit_hold", {31'd0, resp_hit}, {31'd0, exp_hit});
         chk("req_ready_after", {31'd0, req_ready}, 32'd1);
      end
   endtask

   task automatic chk_stats();
`ifdef DM_CACHE_STATS_EN
      chk("hit_count", hit_count, mdl_hits);
      chk("miss_count", miss_count, mdl_misses);
`endif
   endtask

   // Stimulus sequence
   initial begin
      logic [31:0] a;
      model_clear();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk_stats();
      reset = 1'b0;
      #1;
      chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

      // Cold miss, hit on the refilled line, conflict eviction, re-miss.
      do_read(32'h0000_1234, 0, 1'b0, 0, 1'b0);
      do_read(32'h0000_1235, 0, 1'b0, 0, 1'b0);
      do_read(32'h0000_2234, 1, 1'b0, 0, 1'b0);
      do_read(32'h0000_1234, 0, 1'b0, 0, 1'b0);
      chk("direct_hits", mdl_hits, 32'd1);
      chk("direct_misses", mdl_misses, 32'd3);
      chk_stats();
      do_reset();
      chk_stats();

      // Reset in the middle of a refill, then the same line must miss again.
      do_read(32'h0000_5670, 0, 1'b0, 5, 1'b0);
      do_read(32'h0000_5670, 0, 1'b0, 0, 1'b0);
      do_read(32'h0000_567F, 0, 1'b0, 0, 1'b0);

      // Request held high through a stalled refill.
      do_read(32'h0000_9AB3, 3, 1'b1, 0, 1'b1);
      do_read(32'h0000_9AB8, 0, 1'b0, 0, 1'b1);

      // Random traffic over a few tags and indexes to mix hits, misses and evictions.
      for (int n = 0; n < 60; n++) begin
         a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 4)
             | 32'($urandom_range(0, 15));
         do_read(a, $urandom_range(0, 2), 1'b0, 0, 1'($urandom_range(0, 1)));
      end
      chk_stats();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
